// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster timing generator (sync, data-enable, coordinates)
// with a per-line prefetch request/acknowledge toward the line fetcher.
module video_timing_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        running,
    output logic        hsync,
    output logic        vsync,
    output logic        draw,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start,
    output logic        line_req,
    output logic [11:0] line_num,
    input  logic        line_ack,
    output logic        underflow
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] HA     = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] VA     = 12'(V_ACTIVE);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] VA_END = 12'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [11:0] x_n;
    logic [11:0] y_n;
    logic [11:0] next_line;
    logic [11:0] line_num_n;
    logic        run_n;
    logic        req_set;
    logic        line_req_n;
    logic        underflow_n;
    logic        draw_n;
    logic        hsync_n;
    logic        vsync_n;
    logic        frame_start_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x     <= 12'd0;
            y     <= 12'd0;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
        end
    end

    // STOP only retires once the last active line has been scanned out
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (enable) state_n = RUN;
            RUN:  if (!enable) state_n = STOP;
            STOP: begin
                if (enable)
                    state_n = RUN;
                else if (x == H_LAST && y == VA_END)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        x_n = x + 12'd1;
        y_n = y;
        if (x == H_LAST) begin
            x_n = 12'd0;
            y_n = (y == V_LAST) ? 12'd0 : y + 12'd1;
        end
        if (state_n == IDLE) begin
            x_n = 12'd0;
            y_n = 12'd0;
        end else if (state == IDLE) begin
            x_n = 12'd0;
            y_n = VA;
        end
    end

    // Decode from the coordinates that will be presented next cycle
    always_comb begin
        run_n     = (state_n != IDLE);
        next_line = (y_n == V_LAST) ? 12'd0 : y_n + 12'd1;
        req_set   = run_n && (x_n == HA) && (next_line < VA);

        underflow_n = run_n && line_req && !line_ack
                   && (x_n == 12'd0) && (y_n == line_num);

        draw_n = run_n && (x_n < HA) && (y_n < VA);

        hsync_n = (run_n && x_n >= HS_BEG && x_n < HS_END)
                ? HSYNC_POL : ~HSYNC_POL;
        vsync_n = (run_n && y_n >= VS_BEG && y_n < VS_END)
                ? VSYNC_POL : ~VSYNC_POL;

        frame_start_n = run_n && (x_n == 12'd0) && (y_n == 12'd0);

        line_req_n = 1'b0;
        line_num_n = 12'd0;
        if (run_n) begin
            line_num_n = line_num;
            if (req_set) begin
                line_req_n = 1'b1;
                line_num_n = next_line;
            end else begin
                line_req_n = line_req && !line_ack && !underflow_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running     <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            draw        <= 1'b0;
            frame_start <= 1'b0;
            line_req    <= 1'b0;
            line_num    <= 12'd0;
            underflow   <= 1'b0;
        end else begin
            running     <= run_n;
            hsync       <= hsync_n;
            vsync       <= vsync_n;
            draw        <= draw_n;
            frame_start <= frame_start_n;
            line_req    <= line_req_n;
            line_num    <= line_num_n;
            underflow   <= underflow_n;
        end
    end

endmodule
